mux_scan_sequencer: RTL and testbench
=====================================

// Module: mux_scan_sequencer
// PURPOSE
//  Upstream controller for the 4-lane 4:1 mux (mux16for4). Drives its s0/s1 selects,
//  stepping through the enabled source channels (a,b,c,d) one at a time.
//  Waits a fixed settle time after each select change, then captures the mux's
//  4-bit output y3..y0. Presents each captured word downstream with a valid/ready handshake.
// PARAMETERS
//  SETTLE_CYCLES  2        cycles from a select change to capture; legal range 1..15
//  CH_MASK        4'b1111  enabled channels; bit0=a, bit1=b, bit2=c, bit3=d
// PORTS
//  clk       in   1  single clock, rising edge
//  rst_n     in   1  asynchronous, active-low reset
//  start     in   1  one-cycle request to begin a scan
//  y         in   4  mux outputs {y3,y2,y1,y0}
//  ready     in   1  downstream accepts data_out this cycle
//  s0        out  1  mux select MSB (channel index bit 1)
//  s1        out  1  mux select LSB (channel index bit 0)
//  data_out  out  4  captured y word
//  chan_out  out  2  channel index of data_out (0=a, 1=b, 2=c, 3=d)
//  valid     out  1  data_out/chan_out valid
//  busy      out  1  scan in progress
//  done      out  1  one-cycle pulse when the scan completes
// BEHAVIOUR
//  - Channel index ch = {s0,s1}: 00=a, 01=b, 10=c, 11=d (matches the mux decode).
//  - Reset (async, immediate): state=IDLE. s0=s1=0, data_out=0, chan_out=0.
//    valid=busy=done=0. Settle counter=0.
//  - Reset deasserted mid-scan: the scan is lost; the next start begins a new scan.
//  - FSM states: IDLE, SETTLE, HOLD.
//  - IDLE: s0/s1 held at 0.
//    start=1 and CH_MASK!=0: select the lowest enabled channel, busy<=1, cnt<=SETTLE_CYCLES-1, go SETTLE.
//    start=1 and CH_MASK==0: done pulses for 1 cycle, stay IDLE, no data.
//  - SETTLE: while cnt!=0, decrement cnt.
//    When cnt==0: data_out<=y, chan_out<=ch, valid<=1, go HOLD.
//    Net timing: valid rises exactly SETTLE_CYCLES edges after the edge that changed s0/s1.
//  - HOLD: s0/s1/data_out/chan_out held stable while valid=1.
//    valid&&ready: valid<=0 on that edge, then:
//      more enabled channels above ch: select the next higher enabled channel, reload cnt, go SETTLE.
//      ch is the last enabled channel: done<=1 for 1 cycle, busy<=0, s0/s1<=0, go IDLE.
//  - ready while valid=0: ignored.
//  - start while busy=1: ignored; it is not queued.
//  - Selects change only in IDLE->SETTLE and HOLD->SETTLE/IDLE transitions.
//  - At least SETTLE_CYCLES cycles separate consecutive captures.
//  - Per enabled channel, minimum cost is SETTLE_CYCLES+1 cycles when ready is held high.
// CONFIGURATION
//  CONTINUOUS_SCAN_EN defined:
//    After the last channel's handshake, done still pulses, busy stays 1.
//    If start=1 on that edge, wrap to the lowest enabled channel and go SETTLE.
//    start is therefore a level "run" in this mode. If start=0, go IDLE as normal.
//  CONTINUOUS_SCAN_EN undefined:
//    Single-pass only; start is sampled in IDLE only.
// TESTING
//  1. Reset: assert rst_n=0 mid-HOLD -> s0,s1,valid,busy,done,data_out all 0 immediately (no clock needed).
//  2. Full scan, defaults, ready=1, y tracks the source:
//     expect words {a,b,c,d} with chan_out 0,1,2,3 and s0s1 = 00,01,10,11.
//     valid is 2 cycles after each select change; done pulses once; total 12 cycles start->done.
//  3. Backpressure: ready=0 for 5 cycles in HOLD on ch1 ->
//     data_out, chan_out, s0, s1 stable and valid=1 throughout; the scan resumes one edge after ready=1.
//  4. CH_MASK=4'b1010:
//     only chan_out 1 then 3 are emitted; s0s1 never shows 00 or 10 while busy; done after the ch3 handshake.
//  5. start pulsed while busy -> ignored.
//     CH_MASK=0 with start -> single done pulse, busy stays 0, valid stays 0.
//  6. CONTINUOUS_SCAN_EN with start held 1 -> chan_out sequence 0,1,2,3,0,1... with done at each wrap.
//     Drop start before the ch3 handshake -> IDLE after ch3.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Scans the enabled mux channels, waits for the selects to settle, captures y and hands each word downstream.
// Optional CONTINUOUS_SCAN_EN: with start held high the scan wraps to the lowest enabled channel after the last.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  CH_MASK       = 4'b1111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] y,
  input  logic       ready,
  output logic       s0,
  output logic       s1,
  output logic [3:0] data_out,
  output logic [1:0] chan_out,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned CH_W   = 2;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CH_W-1:0]     chan_q, chan_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CH_W:0]       first_c, next_c;
  logic                wrap_c;

  // Lowest enabled channel at or above lo; MSB flags that one exists.
  function automatic logic [CH_W:0] find_from(input logic [CH_W:0] lo);
    logic [CH_W:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      if (CH_MASK[2'(i)] && (i >= int'(lo))) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  assign first_c = find_from(3'd0);
  assign next_c  = find_from({1'b0, ch_q} + 3'd1);

`ifdef CONTINUOUS_SCAN_EN
  assign wrap_c = start & first_c[CH_W];
`else
  assign wrap_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && first_c[CH_W]) state_d = SETTLE;
      SETTLE:  if (cnt_q == '0) state_d = HOLD;
      HOLD:    if (ready) state_d = (next_c[CH_W] || wrap_c) ? SETTLE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered select, capture and status outputs.
  always_comb begin
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        ch_d = '0;
        if (start) begin
          if (first_c[CH_W]) begin
            ch_d   = first_c[CH_W-1:0];
            cnt_d  = RELOAD;
            busy_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          data_d  = y;
          chan_d  = ch_q;
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (ready) begin
          valid_d = 1'b0;
          cnt_d   = RELOAD;
          if (next_c[CH_W]) begin
            ch_d = next_c[CH_W-1:0];
          end else begin
            done_d = 1'b1;
            if (wrap_c) begin
              ch_d = first_c[CH_W-1:0];
            end else begin
              ch_d   = '0;
              busy_d = 1'b0;
            end
          end
        end
      end
      default: begin
        ch_d    = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign s0       = ch_q[1];
  assign s1       = ch_q[0];
  assign data_out = data_q;
  assign chan_out = chan_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: default mask, mask 4'b1010 and mask 0 instances.
// Define CONTINUOUS_SCAN_EN for both files to exercise the wrapping scan.
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, ready = 1'b0;
  logic [3:0] y, data_out;
  logic [1:0] chan_out;
  logic       s0, s1, valid, busy, done;

  logic       m_start = 1'b0, m_ready = 1'b0;
  logic [3:0] m_y, m_data_out;
  logic [1:0] m_chan_out;
  logic       m_s0, m_s1, m_valid, m_busy, m_done;

  logic       z_start = 1'b0, z_ready = 1'b0;
  logic [3:0] z_y, z_data_out;
  logic [1:0] z_chan_out;
  logic       z_s0, z_s1, z_valid, z_busy, z_done;

  int nvec = 0;
  int nerr = 0;

  // Source words seen on mux channels a,b,c,d.
  function automatic logic [3:0] src_of(input logic [1:0] c);
    case (c)
      2'd0:    return 4'h5;
      2'd1:    return 4'hA;
      2'd2:    return 4'h3;
      default: return 4'hC;
    endcase
  endfunction

  assign y   = src_of({s0, s1});
  assign m_y = src_of({m_s0, m_s1});
  assign z_y = src_of({z_s0, z_s1});

  mux_scan_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y(y), .ready(ready),
    .s0(s0), .s1(s1), .data_out(data_out), .chan_out(chan_out),
    .valid(valid), .busy(busy), .done(done)
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(2), .CH_MASK(4'b1010)) dut_m (
    .clk(clk), .rst_n(rst_n), .start(m_start), .y(m_y), .ready(m_ready),
    .s0(m_s0), .s1(m_s1), .data_out(m_data_out), .chan_out(m_chan_out),
    .valid(m_valid), .busy(m_busy), .done(m_done)
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(2), .CH_MASK(4'b0000)) dut_z (
    .clk(clk), .rst_n(rst_n), .start(z_start), .y(z_y), .ready(z_ready),
    .s0(z_s0), .s1(z_s1), .data_out(z_data_out), .chan_out(z_chan_out),
    .valid(z_valid), .busy(z_busy), .done(z_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected {s0,s1,valid,busy,done} k cycles after the start edge, full mask, ready high.
  function automatic logic [4:0] full_exp(input int k);
    logic [1:0] sel;
    if (k < 12) begin
      sel = 2'(k / 3);
      return {sel, (k % 3) == 2, 1'b1, 1'b0};
    end
    if (k == 12) return 5'b00001;
    return 5'b00000;
  endfunction

  // Same for mask 4'b1010: channel b then d.
  function automatic logic [4:0] mask_exp(input int k);
    if (k < 3) return {2'b01, k == 2, 1'b1, 1'b0};
    if (k < 6) return {2'b11, k == 5, 1'b1, 1'b0};
    if (k == 6) return 5'b00001;
    return 5'b00000;
  endfunction

  // Continuous mode, start held until k==20: two passes, done at wrap and at final exit.
  function automatic logic [4:0] cont_exp(input int k);
    int j;
    logic [1:0] sel;
    if (k < 24) begin
      j = k % 12;
      sel = 2'(j / 3);
      return {sel, (j % 3) == 2, 1'b1, k == 12};
    end
    if (k == 24) return 5'b00001;
    return 5'b00000;
  endfunction

  task automatic test_reset;
    nvec++;
    if ({s0, s1, valid, busy, done, data_out, chan_out} !== 11'b0) begin
      nerr++;
      $display("FAIL reset_dflt got %b exp 0", {s0, s1, valid, busy, done, data_out, chan_out});
    end
    nvec++;
    if ({m_s0, m_s1, m_valid, m_busy, m_done, m_data_out, m_chan_out} !== 11'b0) begin
      nerr++;
      $display("FAIL reset_mask got %b exp 0", {m_s0, m_s1, m_valid, m_busy, m_done, m_data_out, m_chan_out});
    end
  endtask

  task automatic test_full_scan;
    logic [4:0] e;
    ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k <= 13; k++) begin
      e = full_exp(k);
      nvec++;
      if ({s0, s1, valid, busy, done} !== e) begin
        nerr++;
        $display("FAIL full_scan k=%0d status got %b exp %b", k, {s0, s1, valid, busy, done}, e);
      end
      if (e[2]) begin
        nvec++;
        if ({chan_out, data_out} !== {2'(k / 3), src_of(2'(k / 3))}) begin
          nerr++;
          $display("FAIL full_scan_data k=%0d got %h exp %h", k, {chan_out, data_out},
                   {2'(k / 3), src_of(2'(k / 3))});
        end
      end
      tick;
    end
  endtask

  task automatic test_backpressure;
    int n;
    ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (!valid && n < 20) begin tick; n++; end
    nvec++;
    if (valid !== 1'b1 || chan_out !== 2'd0) begin
      nerr++;
      $display("FAIL bp_ch0 got valid=%b chan=%0d exp valid=1 chan=0", valid, chan_out);
    end
    ready = 1'b1;
    tick;
    ready = 1'b0;
    n = 0;
    while (!valid && n < 20) begin tick; n++; end
    for (int i = 0; i < 6; i++) begin
      nvec++;
      if ({s0, s1, valid, busy, chan_out, data_out} !== {2'b01, 1'b1, 1'b1, 2'd1, 4'hA}) begin
        nerr++;
        $display("FAIL bp_hold i=%0d got %b exp %b", i, {s0, s1, valid, busy, chan_out, data_out},
                 {2'b01, 1'b1, 1'b1, 2'd1, 4'hA});
      end
      if (i < 5) tick;
    end
    ready = 1'b1;
    tick;
    nvec++;
    if ({s0, s1, valid, busy} !== 4'b1001) begin
      nerr++;
      $display("FAIL bp_resume got %b exp 1001", {s0, s1, valid, busy});
    end
    n = 0;
    while (!done && n < 30) begin tick; n++; end
    nvec++;
    if (done !== 1'b1) begin
      nerr++;
      $display("FAIL bp_done timeout got done=%b exp 1", done);
    end
    tick;
  endtask

  task automatic test_mask;
    logic [4:0] e;
    m_ready = 1'b1;
    m_start = 1'b1;
    tick;
    m_start = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      e = mask_exp(k);
      nvec++;
      if ({m_s0, m_s1, m_valid, m_busy, m_done} !== e) begin
        nerr++;
        $display("FAIL mask k=%0d status got %b exp %b", k, {m_s0, m_s1, m_valid, m_busy, m_done}, e);
      end
      if (e[2]) begin
        nvec++;
        if ({m_chan_out, m_data_out} !== ((k == 2) ? {2'd1, 4'hA} : {2'd3, 4'hC})) begin
          nerr++;
          $display("FAIL mask_data k=%0d got %h exp %h", k, {m_chan_out, m_data_out},
                   (k == 2) ? {2'd1, 4'hA} : {2'd3, 4'hC});
        end
      end
      tick;
    end
  endtask

  task automatic test_start_ignored;
    logic [4:0] e;
    ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      e = full_exp(k);
      nvec++;
      if ({s0, s1, valid, busy, done} !== e) begin
        nerr++;
        $display("FAIL start_ignored k=%0d status got %b exp %b", k, {s0, s1, valid, busy, done}, e);
      end
      start = (k == 4 || k == 7 || k == 10);
      tick;
    end
    start = 1'b0;
  endtask

  task automatic test_zero_mask;
    z_ready = 1'b1;
    z_start = 1'b1;
    tick;
    z_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if ({z_s0, z_s1, z_valid, z_busy, z_done} !== {4'b0000, k == 0}) begin
        nerr++;
        $display("FAIL zero_mask k=%0d got %b exp %b", k, {z_s0, z_s1, z_valid, z_busy, z_done},
                 {4'b0000, k == 0});
      end
      tick;
    end
  endtask

`ifdef CONTINUOUS_SCAN_EN
  task automatic test_continuous;
    logic [4:0] e;
    ready = 1'b1;
    start = 1'b1;
    tick;
    for (int k = 0; k <= 27; k++) begin
      e = cont_exp(k);
      nvec++;
      if ({s0, s1, valid, busy, done} !== e) begin
        nerr++;
        $display("FAIL continuous k=%0d status got %b exp %b", k, {s0, s1, valid, busy, done}, e);
      end
      if (e[2]) begin
        nvec++;
        if (chan_out !== 2'((k % 12) / 3)) begin
          nerr++;
          $display("FAIL continuous_chan k=%0d got %0d exp %0d", k, chan_out, (k % 12) / 3);
        end
      end
      if (k == 20) start = 1'b0;
      tick;
    end
  endtask
`endif

  task automatic test_reset_mid_hold;
    ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    nvec++;
    if (valid !== 1'b1) begin
      nerr++;
      $display("FAIL rst_pre_hold got valid=%b exp 1", valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({s0, s1, valid, busy, done, data_out, chan_out} !== 11'b0) begin
      nerr++;
      $display("FAIL rst_async got %b exp 0", {s0, s1, valid, busy, done, data_out, chan_out});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      nvec++;
      if ({s0, s1, valid, busy, done} !== 5'b0) begin
        nerr++;
        $display("FAIL rst_scan_lost k=%0d got %b exp 0", k, {s0, s1, valid, busy, done});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    test_reset;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick;
    test_full_scan;
    test_backpressure;
    test_mask;
    test_start_ignored;
    test_zero_mask;
`ifdef CONTINUOUS_SCAN_EN
    test_continuous;
`endif
    test_reset_mid_hold;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
